// File: rtl/timer_digit_register_countdown_pkg.sv
// Shared constants and types for the MM:SS keypad/countdown digit register.
package timer_digit_register_countdown_pkg;

  localparam int unsigned BCD_W                 = 4;
  localparam int unsigned NDIGITS_DEFAULT       = 4;
  localparam logic [3:0]  BCD_MAX               = 4'd9;
  localparam logic [3:0]  SEC_TENS_WRAP_DEFAULT = 4'd5;

  typedef logic [BCD_W-1:0] bcd_t;

  // IDLE: keypad entry allowed. COUNT: decrement on ticks.
  // EXPIRED: count enabled but register already 00:00, nothing acts.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_EXPIRED = 2'd2
  } mode_e;

endpackage

// File: rtl/timer_digit_register_countdown_bcd_digit_down.sv
// Single BCD digit decrementer; a borrow from a zero digit reloads WRAP
// and passes the borrow on to the next more significant digit.
module bcd_digit_down
  import timer_digit_register_countdown_pkg::*;
#(
  parameter bcd_t WRAP = BCD_MAX
) (
  input  logic [BCD_W-1:0] digit_i,
  input  logic             borrow_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             borrow_o
);

  // Decrement when borrowed from, wrapping and borrowing onward at zero.
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == '0) begin
        digit_o  = WRAP;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/timer_digit_register_countdown.sv
// MM:SS digit register: keypad digits shift in right-to-left while idle,
// and the value counts down once per 1 Hz tick while enabled.
module timer_digit_register_countdown
  import timer_digit_register_countdown_pkg::*;
#(
  parameter int unsigned NDIGITS       = NDIGITS_DEFAULT,
  parameter bcd_t        SEC_TENS_WRAP = SEC_TENS_WRAP_DEFAULT
) (
  input  logic             clock_100Hz,
  input  logic             clearn,
  input  logic [BCD_W-1:0] D,
  input  logic             loadn,
  input  logic             pgt_1Hz,
  input  logic             startn,
  input  logic             clrdigitsn,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             zero,
  output logic             done
);

  bcd_t         dig_q   [NDIGITS];
  bcd_t         dig_d   [NDIGITS];
  bcd_t         dig_dec [NDIGITS];
  logic [NDIGITS:0] borrow;
  logic         loadn_q, pgt_q;
  logic         done_q, done_d;
  logic         load_ev, tick_ev, dec_zero;
  mode_e        mode;

  assign load_ev = loadn_q & ~loadn;
  assign tick_ev = ~pgt_q & pgt_1Hz;

  // Chain always computes value-minus-one; the next-state mux decides
  // whether to take it. Index 0 is seconds ones.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < NDIGITS; i++) begin : g_chain
    bcd_digit_down #(
      .WRAP((i == 1) ? SEC_TENS_WRAP : BCD_MAX)
    ) u_digit (
      .digit_i  (dig_q[i]),
      .borrow_i (borrow[i]),
      .digit_o  (dig_dec[i]),
      .borrow_o (borrow[i+1])
    );
  end

  // All-zero flags for the current and the decremented value.
  always_comb begin
    zero     = 1'b1;
    dec_zero = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (dig_q[i] != '0)   zero     = 1'b0;
      if (dig_dec[i] != '0) dec_zero = 1'b0;
    end
  end

  // Operating mode from the count enable and the register contents.
  always_comb begin
    mode = MODE_IDLE;
    if (!startn) mode = zero ? MODE_EXPIRED : MODE_COUNT;
  end

  // Next digit value: clear beats load beats tick; a final borrow-out
  // (underflow past 00:00) is never committed.
  always_comb begin
    dig_d  = dig_q;
    done_d = 1'b0;
    if (!clrdigitsn) begin
      for (int unsigned i = 0; i < NDIGITS; i++) dig_d[i] = '0;
    end else if (mode == MODE_IDLE && load_ev && D <= BCD_MAX) begin
      dig_d[0] = D;
      for (int unsigned i = 1; i < NDIGITS; i++) dig_d[i] = dig_q[i-1];
    end else if (mode == MODE_COUNT && tick_ev && !borrow[NDIGITS]) begin
      dig_d  = dig_dec;
      done_d = dec_zero;
    end
  end

  // State registers; edge-detect history resets high so no false edge follows reset.
  always_ff @(posedge clock_100Hz or negedge clearn) begin
    if (!clearn) begin
      for (int unsigned i = 0; i < NDIGITS; i++) dig_q[i] <= '0;
      loadn_q <= 1'b1;
      pgt_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      loadn_q <= loadn;
      pgt_q   <= pgt_1Hz;
      done_q  <= done_d;
    end
  end

  assign sec_ones = dig_q[0];
  assign sec_tens = dig_q[1];
  assign min_ones = dig_q[2];
  assign min_tens = dig_q[3];
  assign done     = done_q;

endmodule

// File: tb/tb_timer_digit_register_countdown.sv
// Self-checking bench: the register is modelled as a 4-digit decimal number
// with minutes/seconds arithmetic; every cycle the DUT is compared to it.
module tb_timer_digit_register_countdown;

  logic       clock_100Hz = 1'b0;
  logic       clearn, loadn, pgt_1Hz, startn, clrdigitsn;
  logic [3:0] D;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero, done;

  int total = 0;
  int bad   = 0;

  int num;
  bit m_ld, m_pgt, m_done;
  int done_cnt;

  timer_digit_register_countdown #(
    .NDIGITS       (4),
    .SEC_TENS_WRAP (4'd5)
  ) dut (
    .clock_100Hz (clock_100Hz),
    .clearn      (clearn),
    .D           (D),
    .loadn       (loadn),
    .pgt_1Hz     (pgt_1Hz),
    .startn      (startn),
    .clrdigitsn  (clrdigitsn),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .zero        (zero),
    .done        (done)
  );

  always #5 clock_100Hz = ~clock_100Hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd4(input int n);
    bcd4 = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] digits();
    digits = {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Reference behaviour for one clock edge.
  task automatic model_step();
    bit ld_ev, tk_ev;
    int mm, ss;
    ld_ev  = m_ld && !loadn;
    tk_ev  = !m_pgt && pgt_1Hz;
    m_done = 1'b0;
    if (!clearn) begin
      num = 0; m_ld = 1'b1; m_pgt = 1'b1;
      return;
    end
    if (!clrdigitsn) begin
      num = 0;
    end else if (startn) begin
      if (ld_ev && D <= 4'd9) num = (num % 1000) * 10 + int'(D);
    end else if (num != 0 && tk_ev) begin
      mm = num / 100;
      ss = num % 100;
      if (ss > 0) ss--;
      else begin ss = 59; mm--; end
      num    = mm * 100 + ss;
      m_done = (num == 0);
    end
    m_ld  = loadn;
    m_pgt = pgt_1Hz;
  endtask

  task automatic cyc();
    @(posedge clock_100Hz);
    model_step();
    #1;
    chk("digits", digits(), bcd4(num));
    chk("zero", zero, num == 0);
    chk("done", done, m_done);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic load(input logic [3:0] d);
    D = d; loadn = 1'b0;
    cyc(); cyc();
    loadn = 1'b1;
    cyc();
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1; cyc();
    pgt_1Hz = 1'b0; cyc();
  endtask

  task automatic clear_digits();
    clrdigitsn = 1'b0; cyc();
    clrdigitsn = 1'b1; cyc();
  endtask

  initial begin
    clearn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1;
    clrdigitsn = 1'b1; D = 4'd0;
    num = 0; m_ld = 1'b1; m_pgt = 1'b1; m_done = 1'b0; done_cnt = 0;

    #3;
    chk("rst_digits", digits(), 16'h0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_done", done, 1'b0);
    cyc(); cyc();
    clearn = 1'b1;
    cyc();

    // Keypad entry
    load(4'd1); chk("entry_1", digits(), 16'h0001);
    load(4'd2); chk("entry_12", digits(), 16'h0012);
    load(4'd3); chk("entry_123", digits(), 16'h0123);
    chk("entry_zero", zero, 1'b0);

    // Invalid digit, then a long held strobe
    load(4'd12); chk("invalid_d", digits(), 16'h0123);
    D = 4'd4; loadn = 1'b0;
    repeat (30) cyc();
    loadn = 1'b1; cyc();
    chk("held_load", digits(), 16'h1234);

    // 01:00 down to 00:00
    clear_digits();
    load(4'd1); load(4'd0); load(4'd0);
    chk("entry_0100", digits(), 16'h0100);
    startn = 1'b0; cyc();
    done_cnt = 0;
    tick(); chk("first_borrow", digits(), 16'h0059);
    repeat (58) tick();
    chk("at_0001", digits(), 16'h0001);
    chk("no_early_done", done_cnt, 0);
    tick();
    chk("at_0000", digits(), 16'h0000);
    chk("done_once_60", done_cnt, 1);
    repeat (3) tick();
    chk("hold_0000", digits(), 16'h0000);
    chk("zero_hold", zero, 1'b1);
    chk("done_still_once", done_cnt, 1);

    // 00:99 counts through all seconds values, no wrap
    startn = 1'b1; cyc();
    clear_digits();
    load(4'd9); load(4'd9);
    chk("entry_0099", digits(), 16'h0099);
    startn = 1'b0; cyc();
    done_cnt = 0;
    repeat (9) tick(); chk("at_0090", digits(), 16'h0090);
    tick();            chk("at_0089", digits(), 16'h0089);
    repeat (89) tick(); chk("end_0099", digits(), 16'h0000);
    chk("done_once_99", done_cnt, 1);
    repeat (2) tick(); chk("no_wrap", digits(), 16'h0000);

    // Simultaneous load and tick while counting
    startn = 1'b1; cyc();
    clear_digits();
    load(4'd3); load(4'd0);
    chk("entry_0030", digits(), 16'h0030);
    startn = 1'b0; cyc();
    D = 4'd7; loadn = 1'b0; pgt_1Hz = 1'b1; cyc();
    loadn = 1'b1; pgt_1Hz = 1'b0; cyc();
    chk("load_ign_cnt", digits(), 16'h0029);
    startn = 1'b1; cyc();
    load(4'd7);
    chk("paused_load", digits(), 16'h0297);

    // Clear together with a tick mid-count
    startn = 1'b0; cyc();
    tick(); tick();
    chk("at_0295", digits(), 16'h0295);
    clrdigitsn = 1'b0; pgt_1Hz = 1'b1; cyc();
    chk("clr_prio", digits(), 16'h0000);
    chk("clr_done", done, 1'b0);
    clrdigitsn = 1'b1; pgt_1Hz = 1'b0; cyc();

    // Asynchronous reset between edges mid-count
    startn = 1'b1; cyc();
    load(4'd4); load(4'd5);
    startn = 1'b0; cyc();
    tick();
    chk("at_0044", digits(), 16'h0044);
    #2;
    clearn = 1'b0;
    num = 0; m_ld = 1'b1; m_pgt = 1'b1; m_done = 1'b0;
    #1;
    chk("async_digits", digits(), 16'h0000);
    chk("async_zero", zero, 1'b1);
    chk("async_done", done, 1'b0);
    cyc();
    clearn = 1'b1; startn = 1'b1;
    cyc();

    // Randomized traffic against the model
    repeat (3000) begin
      loadn      = ($urandom_range(0, 3) != 0);
      D          = 4'($urandom_range(0, 15));
      pgt_1Hz    = ($urandom_range(0, 2) == 0);
      clrdigitsn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 19) == 0) startn = ~startn;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
